// File: rtl/mm_addr_decoder_gen.sv
// Memory-mapped register-bus decoder: registers one host request per cycle, fans it out
// to NUM_SLV slaves, tracks one outstanding read with a timeout and error counters.
module mm_addr_decoder_gen #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int SEL_LSB = 10,
  parameter int NUM_SLV = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         iMM_ADDR,
  input  logic                      iMM_WR_EN,
  input  logic                      iMM_RD_EN,
  input  logic [DATA_W-1:0]         iMM_WR_DATA,
  output logic [DATA_W-1:0]         oMM_RD_DATA,
  output logic                      oMM_RD_DATA_V,
  output logic                      oMM_BUSY,
  output logic [ADDR_W-1:0]         SLV_ADDR,
  output logic [DATA_W-1:0]         SLV_WR_DATA,
  output logic [NUM_SLV-1:0]        SLV_WR_EN,
  output logic [NUM_SLV-1:0]        SLV_RD_EN,
  input  logic [NUM_SLV*DATA_W-1:0] SLV_RD_DATA,
  input  logic [NUM_SLV-1:0]        SLV_RD_DATA_V,
  output logic [15:0]               oTMO_CNT,
  output logic [15:0]               oDROP_CNT
);

  localparam int IDX_W = ADDR_W - SEL_LSB;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Error word: 32-bit tag in the top bits, address in the bottom bits, zeros between.
  function automatic logic [DATA_W-1:0] err_word(input logic [31:0] tag,
                                                 input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: 32] = tag;
    w[ADDR_W-1:0] = addr;
    return w;
  endfunction

  logic [ADDR_W-1:0] laddr_r;
  logic              lwen_r;
  logic              lren_r;
  logic [DATA_W-1:0] lwdata_r;

  state_t            state_r;
  logic [IDX_W-1:0]  sel_q_r;
  logic [ADDR_W-1:0] addr_q_r;
  logic [15:0]       tmo_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_v_r;
  logic [15:0]       tmo_cnt_r;
  logic [15:0]       drop_cnt_r;

  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       idx_ext_s;
  logic              mapped_s;
  logic              launch_s;
  logic              launch_v_s;
  logic [DATA_W-1:0] launch_d_s;
  logic              wait_v_s;
  logic [DATA_W-1:0] wait_d_s;
  logic [NUM_SLV-1:0] wr_en_s;
  logic [NUM_SLV-1:0] rd_en_s;

  // Stage-1 capture of the host request, every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      laddr_r  <= '0;
      lwen_r   <= 1'b0;
      lren_r   <= 1'b0;
      lwdata_r <= '0;
    end else begin
      laddr_r  <= iMM_ADDR;
      lwen_r   <= iMM_WR_EN;
      lren_r   <= iMM_RD_EN;
      lwdata_r <= iMM_WR_DATA;
    end
  end

  // Address decode, per-slave strobes and the two read-data muxes (launch slave, waited slave).
  always_comb begin
    idx_s      = laddr_r[ADDR_W-1:SEL_LSB];
    idx_ext_s  = 32'(idx_s);
    mapped_s   = (idx_ext_s < 32'(NUM_SLV));
    launch_s   = lren_r && (state_r == IDLE);
    launch_v_s = 1'b0;
    launch_d_s = '0;
    wait_v_s   = 1'b0;
    wait_d_s   = '0;
    wr_en_s    = '0;
    rd_en_s    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_ext_s == 32'(i)) begin
        wr_en_s[i] = lwen_r;
        rd_en_s[i] = launch_s;
        launch_v_s = SLV_RD_DATA_V[i];
        launch_d_s = SLV_RD_DATA[i*DATA_W +: DATA_W];
      end else begin
        wr_en_s[i] = 1'b0;
        rd_en_s[i] = 1'b0;
      end
      if (32'(sel_q_r) == 32'(i)) begin
        wait_v_s = SLV_RD_DATA_V[i];
        wait_d_s = SLV_RD_DATA[i*DATA_W +: DATA_W];
      end else begin
        wait_v_s = wait_v_s;
      end
    end
  end

  // Read FSM with registered response, timeout tracking and saturating error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_q_r    <= '0;
      addr_q_r   <= '0;
      tmo_r      <= 16'd0;
      rd_data_r  <= '0;
      rd_v_r     <= 1'b0;
      tmo_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      rd_v_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lren_r) begin
            if (mapped_s) begin
              sel_q_r  <= idx_s;
              addr_q_r <= laddr_r;
              if (launch_v_s) begin
                rd_data_r <= launch_d_s;
                rd_v_r    <= 1'b1;
              end else begin
                state_r <= WAIT;
                tmo_r   <= 16'd0;
              end
            end else begin
              rd_data_r <= err_word(32'h5555_AAAA, laddr_r);
              rd_v_r    <= 1'b1;
            end
          end
        end
        WAIT: begin
          // A valid in the timeout cycle takes priority over the error load.
          if (wait_v_s) begin
            rd_data_r <= wait_d_s;
            rd_v_r    <= 1'b1;
            state_r   <= IDLE;
          end else if (tmo_r == 16'(TIMEOUT - 1)) begin
            rd_data_r <= err_word(32'hDEAD_0BAD, addr_q_r);
            rd_v_r    <= 1'b1;
            state_r   <= IDLE;
            if (tmo_cnt_r != 16'hFFFF) tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end else begin
            tmo_r <= tmo_r + 16'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (lren_r && (state_r != IDLE) && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign SLV_ADDR      = laddr_r;
  assign SLV_WR_DATA   = lwdata_r;
  assign SLV_WR_EN     = mapped_s ? wr_en_s : '0;
  assign SLV_RD_EN     = mapped_s ? rd_en_s : '0;
  assign oMM_RD_DATA   = rd_data_r;
  assign oMM_RD_DATA_V = rd_v_r;
  assign oMM_BUSY      = (state_r == WAIT);
  assign oTMO_CNT      = tmo_cnt_r;
  assign oDROP_CNT     = drop_cnt_r;

endmodule

// File: tb/tb_mm_addr_decoder_gen.sv
// Directed bench for mm_addr_decoder_gen: transaction-level model compared every cycle,
// plus hand-computed literal checks from the test plan.
module tb_mm_addr_decoder_gen;

  localparam int AW  = 14;
  localparam int DW  = 64;
  localparam int SL  = 10;
  localparam int NS  = 5;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0]    mm_addr = '0;
  logic             mm_wr_en = 1'b0;
  logic             mm_rd_en = 1'b0;
  logic [DW-1:0]    mm_wr_data = '0;
  logic [DW-1:0]    mm_rd_data;
  logic             mm_rd_data_v;
  logic             mm_busy;
  logic [AW-1:0]    slv_addr;
  logic [DW-1:0]    slv_wr_data;
  logic [NS-1:0]    slv_wr_en;
  logic [NS-1:0]    slv_rd_en;
  logic [NS*DW-1:0] slv_rd_data = '0;
  logic [NS-1:0]    slv_rd_data_v = '0;
  logic [15:0]      tmo_cnt;
  logic [15:0]      drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_addr_decoder_gen #(.ADDR_W(AW), .DATA_W(DW), .SEL_LSB(SL), .NUM_SLV(NS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .iMM_ADDR(mm_addr), .iMM_WR_EN(mm_wr_en), .iMM_RD_EN(mm_rd_en), .iMM_WR_DATA(mm_wr_data),
    .oMM_RD_DATA(mm_rd_data), .oMM_RD_DATA_V(mm_rd_data_v), .oMM_BUSY(mm_busy),
    .SLV_ADDR(slv_addr), .SLV_WR_DATA(slv_wr_data), .SLV_WR_EN(slv_wr_en), .SLV_RD_EN(slv_rd_en),
    .SLV_RD_DATA(slv_rd_data), .SLV_RD_DATA_V(slv_rd_data_v),
    .oTMO_CNT(tmo_cnt), .oDROP_CNT(drop_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one pending read with an absolute deadline in clock edges.
  int unsigned    edge_n;
  logic [AW-1:0]  req_a;
  logic           req_we, req_re;
  logic [DW-1:0]  req_wd;
  bit             m_busy;
  int unsigned    deadline;
  int             psel;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  exp_data;
  bit             exp_v;
  int             exp_tmo, exp_drop;
  logic [NS-1:0]  exp_wr_en, exp_rd_en;

  always @(posedge clk or negedge rst_n) begin
    int ridx;
    if (!rst_n) begin
      edge_n = 0; req_a = '0; req_we = 0; req_re = 0; req_wd = '0;
      m_busy = 0; deadline = 0; psel = 0; paddr = '0;
      exp_data = '0; exp_v = 0; exp_tmo = 0; exp_drop = 0;
      exp_wr_en = '0; exp_rd_en = '0;
    end else begin
      edge_n++;
      exp_v = 0;
      ridx = int'(req_a) / (1 << SL);
      if (req_re && m_busy && exp_drop < 65535) exp_drop++;
      if (m_busy) begin
        if (slv_rd_data_v[psel]) begin
          exp_data = slv_rd_data[psel*DW +: DW]; exp_v = 1; m_busy = 0;
        end else if (edge_n == deadline) begin
          exp_data = {32'hDEAD0BAD, 18'd0, paddr}; exp_v = 1; m_busy = 0;
          if (exp_tmo < 65535) exp_tmo++;
        end
      end else if (req_re) begin
        if (ridx < NS) begin
          if (slv_rd_data_v[ridx]) begin
            exp_data = slv_rd_data[ridx*DW +: DW]; exp_v = 1;
          end else begin
            m_busy = 1; deadline = edge_n + TMO; psel = ridx; paddr = req_a;
          end
        end else begin
          exp_data = {32'h5555AAAA, 18'd0, req_a}; exp_v = 1;
        end
      end
      req_a = mm_addr; req_we = mm_wr_en; req_re = mm_rd_en; req_wd = mm_wr_data;
      ridx = int'(req_a) / (1 << SL);
      exp_wr_en = (req_we && ridx < NS) ? NS'(1 << ridx) : '0;
      exp_rd_en = (req_re && !m_busy && ridx < NS) ? NS'(1 << ridx) : '0;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("slv_addr",  64'(slv_addr),     64'(req_a));
    chk("slv_wdata", slv_wr_data,       req_wd);
    chk("slv_wr_en", 64'(slv_wr_en),    64'(exp_wr_en));
    chk("slv_rd_en", 64'(slv_rd_en),    64'(exp_rd_en));
    chk("rd_v",      64'(mm_rd_data_v), 64'(exp_v));
    chk("rd_data",   mm_rd_data,        exp_data);
    chk("busy",      64'(mm_busy),      64'(m_busy));
    chk("tmo_cnt",   64'(tmo_cnt),      64'(exp_tmo));
    chk("drop_cnt",  64'(drop_cnt),     64'(exp_drop));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_v(input int s, input logic v, input logic [DW-1:0] d);
    slv_rd_data_v[s] = v;
    slv_rd_data[s*DW +: DW] = d;
  endtask

  initial begin
    tick(1);
    #1;
    chk("reset_rd_v", 64'(mm_rd_data_v), 64'd0);
    chk("reset_busy", 64'(mm_busy), 64'd0);
    chk("reset_data", mm_rd_data, 64'd0);
    tick(1); #2 rst_n = 1'b1;
    tick(2);

    // Mapped read k=0 to idx 2.
    mm_addr = 14'h0805; mm_rd_en = 1'b1;
    tick(1); chk("k0_strobe", 64'(slv_rd_en), 64'b00100);
    mm_rd_en = 1'b0; set_v(2, 1'b1, 64'h1122334455667788);
    tick(1); chk("k0_v", 64'(mm_rd_data_v), 64'd1); chk("k0_data", mm_rd_data, 64'h1122334455667788);
    chk("k0_busy", 64'(mm_busy), 64'd0);
    set_v(2, 1'b0, '0);
    tick(2);

    // Back-to-back zero-latency reads to idx 3.
    mm_addr = 14'h0C00; mm_rd_en = 1'b1;
    tick(1); mm_addr = 14'h0C08; set_v(3, 1'b1, 64'h00000000000000A1);
    tick(1); mm_rd_en = 1'b0; set_v(3, 1'b1, 64'h00000000000000B2);
    chk("b2b_first", mm_rd_data, 64'h00000000000000A1);
    tick(1); set_v(3, 1'b0, '0);
    chk("b2b_second", mm_rd_data, 64'h00000000000000B2);
    tick(2);

    // Slow slave k=6 on idx 4, with a dropped read and a foreign valid mid-wait.
    mm_addr = 14'h1000; mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0;
    tick(2); mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0; chk("drop_no_strobe", 64'(slv_rd_en), 64'd0);
    tick(1); set_v(0, 1'b1, 64'hFFFF);
    tick(1); set_v(0, 1'b0, '0);
    tick(1); set_v(4, 1'b1, 64'h0123456789ABCDEF); chk("k6_busy", 64'(mm_busy), 64'd1);
    tick(1); set_v(4, 1'b0, '0);
    chk("k6_data", mm_rd_data, 64'h0123456789ABCDEF); chk("k6_v", 64'(mm_rd_data_v), 64'd1);
    chk("k6_drop", 64'(drop_cnt), 64'd1); chk("k6_busy_end", 64'(mm_busy), 64'd0);
    tick(2);

    // Unmapped read and write at idx 7.
    mm_addr = 14'h1C00; mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0; chk("unm_strobe", 64'(slv_rd_en), 64'd0);
    tick(1); chk("unm_data", mm_rd_data, 64'h5555AAAA00001C00);
    mm_wr_en = 1'b1; mm_wr_data = 64'h77;
    tick(1); mm_wr_en = 1'b0; chk("unm_wr", 64'(slv_wr_en), 64'd0);
    tick(2);

    // Timeout on idx 1, then a late valid that must be ignored.
    mm_addr = 14'h0400; mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0;
    tick(9); chk("tmo_data", mm_rd_data, 64'hDEAD0BAD00000400);
    chk("tmo_v", 64'(mm_rd_data_v), 64'd1); chk("tmo_cnt1", 64'(tmo_cnt), 64'd1);
    tick(1); set_v(1, 1'b1, 64'h99);
    tick(1); set_v(1, 1'b0, '0); chk("late_v", 64'(mm_rd_data_v), 64'd0);
    tick(2);

    // Write during WAIT on idx 0.
    mm_addr = 14'h0000; mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0;
    tick(2); mm_addr = 14'h0C10; mm_wr_en = 1'b1; mm_wr_data = 64'hA5;
    tick(1); mm_wr_en = 1'b0;
    chk("wwait_en", 64'(slv_wr_en), 64'b01000); chk("wwait_data", slv_wr_data, 64'hA5);
    tick(1); set_v(0, 1'b1, 64'hCAFE);
    tick(1); set_v(0, 1'b0, '0); chk("wwait_rd", mm_rd_data, 64'hCAFE);
    tick(2);

    // Reset mid-WAIT on idx 2; later valid must not produce a response.
    mm_addr = 14'h0800; mm_rd_en = 1'b1;
    tick(1); mm_rd_en = 1'b0;
    tick(2); #2 rst_n = 1'b0;
    #1 chk("rst_busy", 64'(mm_busy), 64'd0); chk("rst_data", mm_rd_data, 64'd0);
    chk("rst_cnt", 64'(tmo_cnt), 64'd0);
    tick(1); #2 rst_n = 1'b1;
    tick(1); set_v(2, 1'b1, 64'h55);
    tick(1); set_v(2, 1'b0, '0); chk("rst_late_v", 64'(mm_rd_data_v), 64'd0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_addr_decoder_gen.md
# mm_addr_decoder_gen

Parametrised memory-mapped register-bus decoder for the link-engine channel. It registers one host request per cycle and fans it out to `NUM_SLV` sub-blocks selected by upper address bits. It tracks a single outstanding read with a timeout, and returns either slave data or a fixed error pattern. Sits between the channel MM port and the per-function register blocks (serdes, MAC, FCE, extractor, stats, ...). It adds busy indication, a read timeout and error counters.

## Interface
Parameters:
- `ADDR_W`, default 14: host address width.
- `DATA_W`, default 64: data width. Constraint: `DATA_W >= ADDR_W+32`.
- `SEL_LSB`, default 10: slave index is `addr[ADDR_W-1:SEL_LSB]`.
- `NUM_SLV`, default 5: number of mapped slaves; indices 0..NUM_SLV-1.
- `TIMEOUT`, default 255: WAIT cycles before a read is aborted. Range 1..65535.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `iMM_ADDR`  in  ADDR_W: request address.
- `iMM_WR_EN`  in  1: write strobe, single cycle.
- `iMM_RD_EN`  in  1: read strobe, single cycle.
- `iMM_WR_DATA`  in  DATA_W: write data.
- `oMM_RD_DATA`  out  DATA_W: read response data.
- `oMM_RD_DATA_V`  out  1: one-cycle response valid.
- `oMM_BUSY`  out  1: a read is outstanding (FSM not IDLE).
- `SLV_ADDR`  out  ADDR_W: registered address, shared by all slaves.
- `SLV_WR_DATA`  out  DATA_W: registered write data, shared by all slaves.
- `SLV_WR_EN`  out  NUM_SLV: per-slave write strobe.
- `SLV_RD_EN`  out  NUM_SLV: per-slave read strobe.
- `SLV_RD_DATA`  in  NUM_SLV*DATA_W: slave i occupies bits `[i*DATA_W +: DATA_W]`.
- `SLV_RD_DATA_V`  in  NUM_SLV: per-slave read valid.
- `oTMO_CNT`  out  16: saturating read-timeout count.
- `oDROP_CNT`  out  16: saturating count of reads dropped while busy.

## Operation
- **Stage 1 registers:** `laddr`, `lwen`, `lren`, `lwdata` capture the host inputs every cycle. `SLV_ADDR = laddr` and `SLV_WR_DATA = lwdata`.
- **Decode:** `idx = laddr[ADDR_W-1:SEL_LSB]`; the access is mapped if `idx < NUM_SLV`.
- **Writes:** `SLV_WR_EN[idx] = lwen & mapped`. Writes are forwarded in every FSM state. Unmapped writes are discarded silently.
- **Read launch:** `launch = lren & (state==IDLE)`.
  - Mapped launch: `SLV_RD_EN[idx]=1`; latch `sel_q=idx` and `addr_q=laddr`.
  - Unmapped launch: no slave strobe; error response `{32'h5555_AAAA, zeros, laddr}` is loaded directly.
- **Drop:** `lren` while not IDLE drops the read. No slave strobe, no response, `oDROP_CNT += 1`.
- **FSM states:** IDLE, WAIT.
  - IDLE -> WAIT on a mapped launch, unless the selected valid is already high in the same cycle. In that case data is captured and the FSM stays in IDLE.
  - WAIT -> IDLE when `SLV_RD_DATA_V[sel_q]` is high: capture that slave's data.
  - WAIT -> IDLE when `tmo == TIMEOUT-1`: load `{32'hDEAD_0BAD, zeros, addr_q}` and increment `oTMO_CNT`.
  - If valid and timeout occur in the same cycle, valid wins.
- **Timeout counter:** `tmo` clears on entry to WAIT and increments each WAIT cycle.
- **Ignored valids:** valids from non-selected slaves are ignored. Valids arriving in IDLE without a launch are ignored.
- **Response register:** any capture or error load writes `oMM_RD_DATA` and pulses `oMM_RD_DATA_V` the next cycle. `oMM_RD_DATA` holds its value until the next response.
- **Counters** saturate at 16'hFFFF.
- **Software restriction:** a slave that timed out must not be re-read until its stale valid is known to have been retired. A stale valid coinciding with a new launch to that slave is accepted as the new read's data.

## Timing
- **Reset values:** all outputs 0. FSM IDLE; `tmo`, counters, `sel_q`, `addr_q`, and the stage-1 registers are 0.
- **Reset mid-WAIT:** FSM returns to IDLE, no response is produced, and later valids are ignored.
- **Strobes:** request at edge T is visible on `SLV_*_EN` during cycle T+1, one cycle wide, derived combinationally from the stage-1 registers.
- **Read latency:** slave valid in cycle T+1+k (k >= 0) gives `oMM_RD_DATA_V` in cycle T+2+k.
- **Unmapped read:** `oMM_RD_DATA_V` in cycle T+2.
- **Timeout:** `oMM_RD_DATA_V` in cycle T+2+TIMEOUT.
- **`oMM_BUSY`:** high from T+2 until the cycle in which the valid or timeout is taken, inclusive.
- **Back-to-back reads:** a zero-latency slave sustains one read per cycle. A slow slave requires the host to honour `oMM_BUSY`.

## Test plan
- **Mapped read, k=0:** read addr 0x0805 (idx 2); slave 2 drives data 0x1122334455667788 with valid in the strobe cycle -> `SLV_RD_EN=5'b00100` at T+1; `oMM_RD_DATA=0x1122334455667788` with valid at T+2; `oMM_BUSY` never high.
- **Slow slave, k=6:** read idx 4; valid 6 cycles after the strobe -> busy for 6 cycles; response at T+8. A second read issued mid-wait is dropped: `oDROP_CNT=1`, no strobe.
- **Unmapped read:** read addr 0x1C00 (idx 7) -> no strobe; response `0x5555AAAA00001C00` at T+2. Write to 0x1C00 -> `SLV_WR_EN=0`.
- **Timeout:** TIMEOUT=8; read idx 1, slave silent -> response `0xDEAD0BAD00000400` at T+10; `oTMO_CNT=1`. A late valid from slave 1 is ignored.
- **Write during WAIT:** while a read to idx 0 waits, write 0x0C10 data 0xA5 -> `SLV_WR_EN=5'b01000` and `SLV_WR_DATA=0xA5` one cycle later. The read completes normally.
- **Reset mid-WAIT:** assert `rst_n=0` for 1 cycle during WAIT -> all outputs 0, busy low; a subsequent slave valid produces no response.
